// File: rtl/adder_accum_seq.sv
// Signed running sum of N_TERMS byte operands (add or subtract each) built on one
// shared 8-bit ripple adder. Each operand takes a low-byte pass, then a high-byte pass.
//
// state | meaning
// IDLE  | waiting for an operand; in_ready high
// LOW   | low byte: acc[7:0] +/- operand, carry captured
// HIGH  | high byte: sign extension plus carry into acc[15:8], term counted
// DONE  | result presented on out_data until out_ready
module adder_accum_seq #(
    parameter int N_TERMS = 9,
    parameter int APPROX  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [8:0] LAST_COUNT = 9'(N_TERMS);

    state_t      state;
    logic [15:0] acc;
    logic [7:0]  count;
    logic        carry;
    logic [7:0]  op;
    logic        sub;

    logic [7:0]  add_a, add_b, add_s;
    logic        add_cin, add_cout, approx_en;
    logic [8:0]  rc;
    logic [8:0]  count_inc;

    assign count_inc = {1'b0, count} + 9'd1;
    assign approx_en = (APPROX != 0) && (state == LOW);

    always_comb begin
        add_a   = acc[7:0];
        add_b   = sub ? ~op : op;
        add_cin = sub;
        if (state == HIGH) begin
            add_a   = acc[15:8];
            add_b   = {8{sub}};
            add_cin = carry;
        end
    end

    // The one adder shared by both passes. Bits 6..7 can switch to an approximate
    // cell (sum = b ^ cin, carry-out = a) during the low-byte pass only.
    assign rc[0] = add_cin;
    for (genvar i = 0; i < 8; i++) begin : g_rca
        logic s_ex, c_ex;
        assign s_ex = add_a[i] ^ add_b[i] ^ rc[i];
        assign c_ex = (add_a[i] & add_b[i]) | (add_a[i] & rc[i]) | (add_b[i] & rc[i]);
        if (i >= 6) begin : g_ap
            logic s_ap, c_ap;
            assign s_ap      = add_b[i] ^ rc[i];
            assign c_ap      = add_a[i];
            assign add_s[i]  = approx_en ? s_ap : s_ex;
            assign rc[i+1]   = approx_en ? c_ap : c_ex;
        end else begin : g_ex
            assign add_s[i]  = s_ex;
            assign rc[i+1]   = c_ex;
        end
    end
    assign add_cout = rc[8];

    assign out_data = acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= 16'h0000;
            count     <= 8'd0;
            carry     <= 1'b0;
            op        <= 8'd0;
            sub       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= 16'h0000;
            count     <= 8'd0;
            carry     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op       <= in_data;
                        sub      <= in_sub;
                        state    <= LOW;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                LOW: begin
                    acc[7:0] <= add_s;
                    carry    <= add_cout;
                    state    <= HIGH;
                end
                HIGH: begin
                    acc[15:8] <= add_s;
                    count     <= count_inc[7:0];
                    if (count_inc == LAST_COUNT) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc       <= 16'h0000;
                        count     <= 8'd0;
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_accum_seq.sv
// Bench for adder_accum_seq (N_TERMS = 9, APPROX = 0): directed runs plus random
// operand/sign/back-pressure runs checked against an integer running-sum model.
module tb_adder_accum_seq;
    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid, in_ready, in_sub, out_valid, out_ready, busy;
    logic [7:0]  in_data;
    logic [15:0] out_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] td[9];
    logic       ts[9];

    adder_accum_seq #(.N_TERMS(9), .APPROX(0)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; waits (bounded) for in_ready, wiggling inputs meanwhile,
    // then presents the operand for exactly one accepting edge.
    task automatic send(input logic [7:0] d, input logic s);
        int k = 0;
        while (!in_ready && k < 30) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            in_sub   = 1'($urandom);
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            chk("ready_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sub   = s;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_sub   = 1'($urandom);
    endtask

    // Sends td/ts, then checks latency, result, stability under back-pressure and release.
    task automatic run_seq(input string tag, input int hold);
        int          sum = 0;
        logic [15:0] exp;
        int          lat = 0;
        out_ready = (hold == 0);
        for (int i = 0; i < 9; i++) begin
            send(td[i], ts[i]);
            sum = ts[i] ? sum - int'(td[i]) : sum + int'(td[i]);
        end
        exp = 16'(sum);
        // out_valid shows up two edges after the accepting edge (third cycle counting
        // the accepting cycle itself)
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            if (out_valid) lat = k;
        end
        chk({tag, "_latency"}, lat, 2);
        chk({tag, "_data"}, out_data, exp);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_data"}, out_data, exp);
            chk({tag, "_hold_ready"}, in_ready, 0);
            chk({tag, "_hold_busy"}, busy, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    task automatic fill(input logic [7:0] d, input logic s);
        for (int i = 0; i < 9; i++) begin
            td[i] = d;
            ts[i] = s;
        end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 8'd0; in_sub = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready_after", in_ready, 1);

        fill(8'd10, 1'b0);
        run_seq("add10", 0);
        fill(8'd255, 1'b0);
        run_seq("add255", 0);
        fill(8'd50, 1'b1);
        td[0] = 8'd200; ts[0] = 1'b0;
        run_seq("sub50", 0);
        fill(8'd3, 1'b0);
        run_seq("hold5", 5);
        fill(8'd4, 1'b0);
        run_seq("after_hold", 0);

        // async reset while term 4 is in its high-byte pass
        for (int i = 0; i < 4; i++) send(8'd77, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", out_data, 16'h0000);
        chk("midrst_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready_after", in_ready, 1);
        fill(8'd1, 1'b0);
        run_seq("after_rst", 0);

        // clr while term 7 is in its low-byte pass
        for (int i = 0; i < 7; i++) send(8'd9, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_ready", in_ready, 1);
        chk("clr_busy", busy, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_data", out_data, 16'h0000);
        fill(8'd2, 1'b0);
        run_seq("after_clr", 0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 9; i++) begin
                td[i] = 8'($urandom);
                ts[i] = 1'($urandom);
            end
            run_seq($sformatf("rand%0d", r), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
